// File: rtl/uart_tx_serializer_if.sv
// Parallel-load / serial-line bundle for the UART transmit serializer.
// Master drives the word and load strobe; slave returns status and the line.
interface uart_tx_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              load_in;
    logic              ready_out;
    logic              data_out;
    logic              busy;
    logic              frame_done;

    modport master (
        output data_in, load_in,
        input  ready_out, data_out, busy, frame_done
    );
    modport slave (
        input  data_in, load_in,
        output ready_out, data_out, busy, frame_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, DATA_W data bits, optional parity,
// 1-2 stop bits, each bit held CLKS_PER_BIT clocks. All outputs registered.
module uart_tx_serializer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1,
    parameter int LSB_FIRST    = 1
) (
    input logic Clk,
    input logic reset,
    uart_tx_serializer_if.slave bus
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_CLK  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     clk_q, clk_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              par_q, par_d;
    logic              line_q, line_d;
    logic              done_q, done_d;
    logic              last_clk;

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            clk_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            clk_q   <= clk_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            line_q  <= line_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clk_d    = clk_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        par_d    = par_q;
        last_clk = (clk_q == LAST_CLK);

        if (state_q != S_IDLE) begin
            clk_d = last_clk ? '0 : clk_q + CW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (bus.load_in) begin
                    shift_d = bus.data_in;
                    par_d   = (^bus.data_in) ^ (PARITY_ODD != 0);
                    clk_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (last_clk) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (last_clk) begin
                    shift_d = (LSB_FIRST != 0) ? (shift_q >> 1) : (shift_q << 1);
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_PARITY: begin
                if (last_clk) begin
                    bit_d   = '0;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (last_clk) begin
                    if (bit_q == LAST_STOP) begin
                        bit_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from next-state values so they land registered.
        unique case (state_d)
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = (LSB_FIRST != 0) ? shift_d[0] : shift_d[DATA_W-1];
            S_PARITY: line_d = par_d;
            default:  line_d = 1'b1;
        endcase
        done_d = (state_d == S_STOP) && (clk_d == LAST_CLK) && (bit_d == LAST_STOP);
    end

    assign bus.ready_out  = (state_q == S_IDLE);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.data_out   = line_q;
    assign bus.frame_done = done_q;
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Parametrised UART transmit serializer that replaces the fixed 8-bit load/shift PISO with a complete framed transmitter. It accepts a parallel word on a valid/ready handshake and emits start, data, optional parity and stop bits. Each bit is held for a parametrised number of clocks. It sits between the TX holding logic and the serial line pin.

Parameters:
DATA_W, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 16, clocks each serial bit is held; must be 1 or more.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.
LSB_FIRST, 1, 1 sends data LSB first, 0 sends MSB first.

Ports:
Clk  input  1  single system clock; all logic is on its rising edge.
reset  input  1  synchronous, active-high reset, sampled on rising Clk.
data_in  input  DATA_W  parallel word; sampled only on an accepted load.
load_in  input  1  valid; a word is accepted when load_in and ready_out are both high at a rising edge.
ready_out  output  1  high only in IDLE; block can accept a word.
data_out  output  1  serial line; idle/mark level is 1.
busy  output  1  high while a frame is in progress (inverse of ready_out).
frame_done  output  1  one-cycle pulse during the final clock of the last stop bit.

Behaviour:
- Reset (reset=1 at an edge, any state):
  - Next cycle: data_out=1, ready_out=1, busy=0, frame_done=0.
  - State goes to IDLE; bit counter, clock counter and shift register are cleared.
  - Reset mid-frame aborts the frame with no partial stop bit.
  - reset has priority over load_in.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE:
  - data_out=1, ready_out=1.
  - On load_in=1: capture data_in into the shift register, compute the parity bit from the captured word, enter START.
- Each bit state holds data_out constant for exactly CLKS_PER_BIT cycles, timed by a clock counter running 0..CLKS_PER_BIT-1.
- Timing: if a word is accepted at edge k, the start bit (0) is driven in cycles k+1 .. k+CLKS_PER_BIT.
- DATA:
  - Sends DATA_W bits, one per bit period.
  - LSB_FIRST=1: bit 0 first, shift right. LSB_FIRST=0: bit DATA_W-1 first, shift left.
  - The bit counter runs 0..DATA_W-1.
- PARITY:
  - Even: XOR of the captured data bits.
  - Odd: the inverted XOR.
- STOP:
  - data_out=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 in the final cycle of the last stop bit.
  - The next state is IDLE.
- Frame length: F = (1 + DATA_W + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
  - ready_out is low in cycles k+1 .. k+F.
  - ready_out is high again in cycle k+F+1.
- Back-to-back: a load held high through the end of a frame is accepted at edge k+F+1. The next start bit begins at k+F+2, so there is no extra idle time beyond the IDLE cycle.
- load_in while busy is ignored. data_in changes after acceptance do not affect the frame in flight.
- CLKS_PER_BIT=1 must work: one clock per bit, F = frame bits.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. DATA_W=8, CLKS_PER_BIT=4, no parity, 1 stop; load 0xA5 at edge k.
   -> Line sequence per 4-cycle bit: 0,1,0,1,0,0,1,0,1,1.
   -> ready_out low cycles k+1..k+40, high at k+41.
   -> frame_done high only at cycle k+40.
2. PARITY_EN=1, even, STOP_BITS=2, CLKS_PER_BIT=4; load 0xA5.
   -> Parity bit 0, then two stop periods; F=48.
   -> Repeat with PARITY_ODD=1: parity bit 1.
   -> Load 0x07 with even parity: parity bit 1.
3. LSB_FIRST=0; load 0xA5.
   -> Data bits on the line: 1,0,1,0,0,1,0,1; start/stop unchanged.
4. During a frame of 0x3C, pulse load_in with 0xFF and change data_in mid-frame.
   -> Frame still carries 0x3C; the 0xFF load is not accepted.
   -> ready_out remains low until the frame ends.
5. Assert reset for 1 cycle in the middle of the data bits.
   -> Next cycle: data_out=1, ready_out=1, busy=0.
   -> A new load 0x55 then produces a full, correct frame.
6. CLKS_PER_BIT=1, load_in held high with 0x01 then 0x80.
   -> Two frames of 10 cycles each, separated by exactly one idle cycle with data_out=1.
